// File: rtl/video_arb_pkg.sv
// Shared types and constants for the video DRAM arbiter: owner encoding,
// DRAM cycle phase markers and the handshake pulse bundle.
package video_arb_pkg;

  localparam int AW_DEF = 21;
  localparam int DW_DEF = 16;
  localparam int BW_W   = 5;

  // Phase whose closing edge takes the grant decision; phase that carries mem_rd.
  localparam logic [1:0] PH_ARB = 2'd2;
  localparam logic [1:0] PH_GO  = 2'd0;

  typedef enum logic [2:0] {
    IDLE,
    VIDEO,
    TM,
    TS,
    CPU
  } owner_e;

  typedef struct packed {
    logic video_pre_next;
    logic video_next;
    logic video_strobe;
    logic tm_next;
    logic tm_strobe;
    logic ts_pre_next;
    logic ts_next;
    logic ts_strobe;
    logic cpu_next;
    logic cpu_strobe;
  } hs_t;

  // Only video and TS get an early warning one clock before their slot.
  function automatic hs_t hs_pre(owner_e o);
    hs_t h = '0;
    h.video_pre_next = (o == VIDEO);
    h.ts_pre_next    = (o == TS);
    return h;
  endfunction

  function automatic hs_t hs_next(owner_e o);
    hs_t h = '0;
    h.video_next = (o == VIDEO);
    h.tm_next    = (o == TM);
    h.ts_next    = (o == TS);
    h.cpu_next   = (o == CPU);
    return h;
  endfunction

  function automatic hs_t hs_strobe(owner_e o);
    hs_t h = '0;
    h.video_strobe = (o == VIDEO);
    h.tm_strobe    = (o == TM);
    h.ts_strobe    = (o == TS);
    h.cpu_strobe   = (o == CPU);
    return h;
  endfunction

endpackage

// File: rtl/video_arb_prio.sv
// Fixed-priority selection of the next DRAM cycle owner. The Z80 low-priority
// flag decides whether a pending CPU access may jump ahead of TS.
module video_arb_prio
  import video_arb_pkg::*;
(
  input  logic   video_pend_i,
  input  logic   tm_req_i,
  input  logic   ts_req_i,
  input  logic   cpu_req_i,
  input  logic   ts_z80_lp_i,
  output owner_e owner_o
);

  always_comb begin
    // NOTE: default first so every path assigns owner_o and no latch is inferred.
    owner_o = IDLE;
    if (video_pend_i) begin
      owner_o = VIDEO;
    end else if (tm_req_i) begin
      owner_o = TM;
    end else if (ts_req_i && !ts_z80_lp_i) begin
      owner_o = TS;
    end else if (cpu_req_i) begin
      owner_o = CPU;
    end else if (ts_req_i) begin
      owner_o = TS;
    end
  end

endmodule

// File: rtl/video_dram_arb.sv
// Video DRAM responder: 4-clock DRAM cycles, one owner per cycle, registered
// address/read strobe and per-requester pre_next/next/strobe pulses.
module video_dram_arb
  import video_arb_pkg::*;
#(
  parameter int AW = AW_DEF,
  parameter int DW = DW_DEF
) (
  input  logic            clk,
  input  logic            res_n,
  input  logic            video_go,
  input  logic [BW_W-1:0] video_bw,
  input  logic [AW-1:0]   video_addr,
  input  logic            tm_req,
  input  logic [AW-1:0]   tm_addr,
  input  logic            ts_req,
  input  logic [AW-1:0]   ts_addr,
  input  logic            ts_z80_lp,
  input  logic            cpu_req,
  input  logic [AW-1:0]   cpu_addr,
  input  logic [DW-1:0]   mem_rdata,
  output logic [AW-1:0]   mem_addr,
  output logic            mem_rd,
  output logic [1:0]      cyc_ph,
  output logic [DW-1:0]   dram_rdata,
  output logic            video_pre_next,
  output logic            video_next,
  output logic            video_strobe,
  output logic            tm_next,
  output logic            tm_strobe,
  output logic            ts_pre_next,
  output logic            ts_next,
  output logic            ts_strobe,
  output logic            cpu_next,
  output logic            cpu_strobe
);

  logic [1:0]      ph_q, ph_d;
  logic [BW_W-1:0] vcnt_q, vcnt_d;
  owner_e          grant_q, grant_d;   // decided at PH_ARB, takes effect at PH_GO
  owner_e          owner_q, owner_d;   // owner of the DRAM cycle in progress
  logic [AW-1:0]   mem_addr_q, mem_addr_d;
  logic            mem_rd_q, mem_rd_d;
  logic [DW-1:0]   rdata_q, rdata_d;
  hs_t             hs_q, hs_d;

  owner_e          decision;
  logic [AW-1:0]   grant_addr;

  video_arb_prio u_prio (
    .video_pend_i (vcnt_q != '0),
    .tm_req_i     (tm_req),
    .ts_req_i     (ts_req),
    .cpu_req_i    (cpu_req),
    .ts_z80_lp_i  (ts_z80_lp),
    .owner_o      (decision)
  );

  always_comb begin
    grant_addr = mem_addr_q;
    case (grant_q)
      VIDEO:   grant_addr = video_addr;
      TM:      grant_addr = tm_addr;
      TS:      grant_addr = ts_addr;
      CPU:     grant_addr = cpu_addr;
      default: grant_addr = mem_addr_q;
    endcase
  end

  always_comb begin
    ph_d       = ph_q + 2'd1;
    vcnt_d     = vcnt_q;
    grant_d    = grant_q;
    owner_d    = owner_q;
    mem_addr_d = mem_addr_q;
    mem_rd_d   = 1'b0;
    rdata_d    = rdata_q;
    hs_d       = '0;

    // Closing edge of the data phase: latch read data, strobe the current
    // owner and pick who gets the following DRAM cycle.
    if (ph_q == PH_ARB) begin
      grant_d = decision;
      if (decision == VIDEO) begin
        vcnt_d = vcnt_q - 1'b1;
      end
      if (owner_q != IDLE) begin
        rdata_d = mem_rdata;
      end
      hs_d = hs_t'(hs_pre(decision) | hs_strobe(owner_q));
    end

    // Cycle boundary: the granted requester's address is sampled here and
    // it is told to advance with its _next pulse.
    if (ph_d == PH_GO) begin
      owner_d = grant_q;
      hs_d    = hs_next(grant_q);
      if (grant_q != IDLE) begin
        mem_rd_d   = 1'b1;
        mem_addr_d = grant_addr;
      end
    end

    // A new burst always wins over the running count, including its decrement.
    if (video_go) begin
      vcnt_d = video_bw;
    end
  end

  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      ph_q       <= '0;
      vcnt_q     <= '0;
      grant_q    <= IDLE;
      owner_q    <= IDLE;
      mem_addr_q <= '0;
      mem_rd_q   <= 1'b0;
      rdata_q    <= '0;
      hs_q       <= '0;
    end else begin
      // NOTE: non-blocking so every register samples pre-edge values together.
      ph_q       <= ph_d;
      vcnt_q     <= vcnt_d;
      grant_q    <= grant_d;
      owner_q    <= owner_d;
      mem_addr_q <= mem_addr_d;
      mem_rd_q   <= mem_rd_d;
      rdata_q    <= rdata_d;
      hs_q       <= hs_d;
    end
  end

  assign cyc_ph         = ph_q;
  assign mem_addr       = mem_addr_q;
  assign mem_rd         = mem_rd_q;
  assign dram_rdata     = rdata_q;
  assign video_pre_next = hs_q.video_pre_next;
  assign video_next     = hs_q.video_next;
  assign video_strobe   = hs_q.video_strobe;
  assign tm_next        = hs_q.tm_next;
  assign tm_strobe      = hs_q.tm_strobe;
  assign ts_pre_next    = hs_q.ts_pre_next;
  assign ts_next        = hs_q.ts_next;
  assign ts_strobe      = hs_q.ts_strobe;
  assign cpu_next       = hs_q.cpu_next;
  assign cpu_strobe     = hs_q.cpu_strobe;

endmodule
